// File: rtl/pwm_cfg_sched.sv
`default_nettype none
// ============================================================================
// Module   : pwm_cfg_sched
// Purpose  : Command scheduler for a bank of pattern_pwm channels. Decodes
//            packets from a UART multi-byte receiver into shadow-register
//            writes and START/STOP requests. A per-channel FSM
//            (IDLE/ARM/RUN/DRAIN) copies the shadow registers to the active
//            set, applies a start delay, enables the channel and waits for
//            the burst to finish or drain.
// Ports    : sys_clk, sys_rst_n       - clock, async active-low reset
//            recv_done                - packet-complete strobe (level ok)
//            dataA/B/C/D              - packet fields (dataA = opcode|channel)
//            pwm_busy, pwm_valid      - per-channel status from pattern_pwm
//            pwm_en                   - per-channel enable (registered)
//            duty_num, pulse_dessert,
//            pulse_num, pat           - active configuration, channel i in slice i
//            cmd_ack, cmd_err         - 1-cycle command response
//            ch_done                  - 1-cycle end-of-burst per channel
//            ch_state                 - per-channel FSM state, 2 bits each
// Revision : 1.0 - initial release
// ============================================================================
module pwm_cfg_sched #(
  parameter int NUM_CH     = 2,
  parameter int _PAT_WIDTH = 16
) (
  input  logic                         sys_clk,
  input  logic                         sys_rst_n,
  input  logic                         recv_done,
  input  logic [7:0]                   dataA,
  input  logic [15:0]                  dataB,
  input  logic [15:0]                  dataC,
  input  logic [7:0]                   dataD,
  input  logic [NUM_CH-1:0]            pwm_busy,
  input  logic [NUM_CH-1:0]            pwm_valid,
  output logic [NUM_CH-1:0]            pwm_en,
  output logic [NUM_CH*8-1:0]          duty_num,
  output logic [NUM_CH*16-1:0]         pulse_dessert,
  output logic [NUM_CH*8-1:0]          pulse_num,
  output logic [NUM_CH*_PAT_WIDTH-1:0] pat,
  output logic                         cmd_ack,
  output logic                         cmd_err,
  output logic [NUM_CH-1:0]            ch_done,
  output logic [NUM_CH*2-1:0]          ch_state
);

  localparam logic [1:0] c_ST_IDLE  = 2'b00;
  localparam logic [1:0] c_ST_ARM   = 2'b01;
  localparam logic [1:0] c_ST_RUN   = 2'b10;
  localparam logic [1:0] c_ST_DRAIN = 2'b11;

  localparam logic [3:0] c_OP_CFG_A = 4'h1;
  localparam logic [3:0] c_OP_CFG_B = 4'h2;
  localparam logic [3:0] c_OP_START = 4'h3;
  localparam logic [3:0] c_OP_STOP  = 4'h4;

  localparam logic [4:0] c_NUM_CH = 5'(NUM_CH);

  logic                  r_recv_d;
  logic                  r_cmd_ack;
  logic                  r_cmd_err;
  logic                  w_cmd_stb;
  logic [3:0]            w_op;
  logic [3:0]            w_ch;
  logic                  w_op_known;
  logic                  w_ch_ok;
  logic                  w_tgt_idle;
  logic                  w_err;
  logic                  w_ack;
  logic [NUM_CH*2-1:0]   w_state_all;
  logic [_PAT_WIDTH-1:0] w_pat_src;

  // Rising-edge detect; the delay register resets to 1 so a recv_done
  // already high when reset releases is not mistaken for a new packet.
  assign w_cmd_stb  = recv_done & ~r_recv_d;
  assign w_op       = dataA[7:4];
  assign w_ch       = dataA[3:0];
  assign w_op_known = (w_op == c_OP_CFG_A) | (w_op == c_OP_CFG_B) |
                      (w_op == c_OP_START) | (w_op == c_OP_STOP);
  assign w_ch_ok    = ({1'b0, w_ch} < c_NUM_CH);

  // State of the addressed channel; false for out-of-range channels.
  always_comb begin
    w_tgt_idle = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (w_ch == 4'(k)) w_tgt_idle = (w_state_all[k*2 +: 2] == c_ST_IDLE);
    end
  end

  assign w_err = w_cmd_stb & w_op_known &
                 (~w_ch_ok | ((w_op == c_OP_START) & ~w_tgt_idle));
  assign w_ack = w_cmd_stb & w_op_known & ~w_err;

  if (_PAT_WIDTH <= 16) begin : g_pat_narrow
    assign w_pat_src = dataB[_PAT_WIDTH-1:0];
  end else begin : g_pat_wide
    assign w_pat_src = {{(_PAT_WIDTH-16){1'b0}}, dataB};
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_recv_d  <= 1'b1;
      r_cmd_ack <= 1'b0;
      r_cmd_err <= 1'b0;
    end else begin
      r_recv_d  <= recv_done;
      r_cmd_ack <= w_ack;
      r_cmd_err <= w_err;
    end
  end

  assign cmd_ack  = r_cmd_ack;
  assign cmd_err  = r_cmd_err;
  assign ch_state = w_state_all;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam logic [3:0] c_IDX = 4'(i);

    logic                  w_hit;
    logic                  w_cfg_a;
    logic                  w_cfg_b;
    logic                  w_start;
    logic                  w_stop;
    logic                  w_load;
    logic                  w_done_nxt;
    logic [1:0]            w_state_nxt;
    logic [15:0]           w_delay_nxt;
    logic [1:0]            r_state;
    logic [15:0]           r_delay;
    logic                  r_en;
    logic                  r_done;
    logic [7:0]            r_sh_duty;
    logic [15:0]           r_sh_des;
    logic [7:0]            r_sh_pnum;
    logic [_PAT_WIDTH-1:0] r_sh_pat;
    logic [7:0]            r_act_duty;
    logic [15:0]           r_act_des;
    logic [7:0]            r_act_pnum;
    logic [_PAT_WIDTH-1:0] r_act_pat;

    assign w_hit   = w_ack & (w_ch == c_IDX);
    assign w_cfg_a = w_hit & (w_op == c_OP_CFG_A);
    assign w_cfg_b = w_hit & (w_op == c_OP_CFG_B);
    assign w_start = w_hit & (w_op == c_OP_START);
    assign w_stop  = w_hit & (w_op == c_OP_STOP);

    always_comb begin
      w_state_nxt = r_state;
      w_delay_nxt = r_delay;
      w_done_nxt  = 1'b0;
      w_load      = 1'b0;
      case (r_state)
        c_ST_IDLE: begin
          if (w_start) begin
            w_load      = 1'b1;
            w_delay_nxt = dataC;
            w_state_nxt = (dataC != 16'd0) ? c_ST_ARM : c_ST_RUN;
          end
        end
        c_ST_ARM: begin
          // STOP wins over delay expiry in the same cycle.
          if (w_stop) begin
            w_state_nxt = c_ST_IDLE;
            w_delay_nxt = 16'd0;
          end else begin
            w_delay_nxt = r_delay - 16'd1;
            if (r_delay == 16'd1) w_state_nxt = c_ST_RUN;
          end
        end
        c_ST_RUN: begin
          // STOP wins over a coincident end-of-burst; a burst count of zero
          // means free-running, so pwm_valid is ignored then.
          if (w_stop) begin
            w_state_nxt = c_ST_DRAIN;
          end else if (pwm_valid[i] && (r_act_pnum != 8'd0)) begin
            w_state_nxt = c_ST_IDLE;
            w_done_nxt  = 1'b1;
          end
        end
        c_ST_DRAIN: begin
          if (!pwm_busy[i]) w_state_nxt = c_ST_IDLE;
        end
        default: w_state_nxt = c_ST_IDLE;
      endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        r_state    <= c_ST_IDLE;
        r_delay    <= 16'd0;
        r_en       <= 1'b0;
        r_done     <= 1'b0;
        r_sh_duty  <= 8'd1;
        r_sh_des   <= 16'd1;
        r_sh_pnum  <= 8'd0;
        r_sh_pat   <= _PAT_WIDTH'(1);
        r_act_duty <= 8'd1;
        r_act_des  <= 16'd1;
        r_act_pnum <= 8'd0;
        r_act_pat  <= _PAT_WIDTH'(1);
      end else begin
        r_state <= w_state_nxt;
        r_delay <= w_delay_nxt;
        // Enable follows the next state so it tracks RUN without lag.
        r_en    <= (w_state_nxt == c_ST_RUN);
        r_done  <= w_done_nxt;
        if (w_cfg_a) begin
          r_sh_des  <= dataB;
          r_sh_duty <= dataD;
        end
        if (w_cfg_b) begin
          r_sh_pat  <= w_pat_src;
          r_sh_pnum <= dataD;
        end
        if (w_load) begin
          r_act_duty <= r_sh_duty;
          r_act_des  <= r_sh_des;
          r_act_pnum <= r_sh_pnum;
          r_act_pat  <= r_sh_pat;
        end
      end
    end

    assign w_state_all[i*2 +: 2]              = r_state;
    assign pwm_en[i]                          = r_en;
    assign ch_done[i]                         = r_done;
    assign duty_num[i*8 +: 8]                 = r_act_duty;
    assign pulse_dessert[i*16 +: 16]          = r_act_des;
    assign pulse_num[i*8 +: 8]                = r_act_pnum;
    assign pat[i*_PAT_WIDTH +: _PAT_WIDTH]    = r_act_pat;
  end

endmodule
`default_nettype wire

// File: tb/tb_pwm_cfg_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_cfg_sched
// Purpose  : Directed self-checking bench for pwm_cfg_sched (NUM_CH=2).
//            Expected command responses are queued when a packet is driven
//            and popped when the response cycle is sampled.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_cfg_sched;

  localparam int NUM_CH = 2;
  localparam int PW     = 16;

  localparam int R_NONE = 0;
  localparam int R_ACK  = 1;
  localparam int R_ERR  = 2;

  logic                 sys_clk = 1'b0;
  logic                 sys_rst_n;
  logic                 recv_done;
  logic [7:0]           dataA;
  logic [15:0]          dataB;
  logic [15:0]          dataC;
  logic [7:0]           dataD;
  logic [NUM_CH-1:0]    pwm_busy;
  logic [NUM_CH-1:0]    pwm_valid;
  logic [NUM_CH-1:0]    pwm_en;
  logic [NUM_CH*8-1:0]  duty_num;
  logic [NUM_CH*16-1:0] pulse_dessert;
  logic [NUM_CH*8-1:0]  pulse_num;
  logic [NUM_CH*PW-1:0] pat;
  logic                 cmd_ack;
  logic                 cmd_err;
  logic [NUM_CH-1:0]    ch_done;
  logic [NUM_CH*2-1:0]  ch_state;

  int n_total  = 0;
  int n_passed = 0;
  int exp_q[$];

  pwm_cfg_sched #(.NUM_CH(NUM_CH), ._PAT_WIDTH(PW)) dut (
    .sys_clk       (sys_clk),
    .sys_rst_n     (sys_rst_n),
    .recv_done     (recv_done),
    .dataA         (dataA),
    .dataB         (dataB),
    .dataC         (dataC),
    .dataD         (dataD),
    .pwm_busy      (pwm_busy),
    .pwm_valid     (pwm_valid),
    .pwm_en        (pwm_en),
    .duty_num      (duty_num),
    .pulse_dessert (pulse_dessert),
    .pulse_num     (pulse_num),
    .pat           (pat),
    .cmd_ack       (cmd_ack),
    .cmd_err       (cmd_err),
    .ch_done       (ch_done),
    .ch_state      (ch_state)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Pop the queued response and compare against the response cycle.
  task automatic check_resp(input string tag);
    int e;
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_empty"}, 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_ack"}, {63'd0, cmd_ack}, {63'd0, e == R_ACK});
      chk({tag, "_err"}, {63'd0, cmd_err}, {63'd0, e == R_ERR});
    end
  endtask

  // One packet: strobe high for one cycle with optional pwm_valid
  // coincident; returns at the falling edge of the response cycle.
  task automatic cmd(input string tag, input logic [3:0] op, input logic [3:0] ch,
                     input logic [15:0] b, input logic [15:0] c, input logic [7:0] d,
                     input int exp, input logic [NUM_CH-1:0] pv);
    @(negedge sys_clk);
    dataA     = {op, ch};
    dataB     = b;
    dataC     = c;
    dataD     = d;
    pwm_valid = pv;
    recv_done = 1'b1;
    exp_q.push_back(exp);
    @(negedge sys_clk);
    recv_done = 1'b0;
    pwm_valid = '0;
    check_resp(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sys_rst_n = 1'b0;
    recv_done = 1'b0;
    dataA = '0; dataB = '0; dataC = '0; dataD = '0;
    pwm_busy = '0; pwm_valid = '0;
    repeat (3) @(negedge sys_clk);

    // Reset state
    chk("rst_state", 64'(ch_state), 64'h0);
    chk("rst_en", 64'(pwm_en), 64'h0);
    chk("rst_duty", 64'(duty_num), 64'h0101);
    chk("rst_des", 64'(pulse_dessert), 64'h0001_0001);
    chk("rst_pnum", 64'(pulse_num), 64'h0);
    chk("rst_pat", 64'(pat), 64'h0001_0001);
    chk("rst_resp", {62'd0, cmd_ack, cmd_err}, 64'd0);
    chk("rst_done", 64'(ch_done), 64'h0);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);

    // CFG_A then START with no delay
    cmd("cfga0", 4'h1, 4'd0, 16'h0010, 16'd0, 8'h05, R_ACK, 2'b00);
    chk("cfga_shadow_only", 64'(duty_num[7:0]), 64'd1);
    cmd("start0", 4'h3, 4'd0, 16'h0, 16'd0, 8'h0, R_ACK, 2'b00);
    chk("start0_state", 64'(ch_state[1:0]), 64'd2);
    chk("start0_en", 64'(pwm_en[0]), 64'd1);
    chk("start0_duty", 64'(duty_num[7:0]), 64'd5);
    chk("start0_des", 64'(pulse_dessert[15:0]), 64'h0010);

    // CFG_A while RUN only touches the shadow set
    cmd("cfga_run", 4'h1, 4'd0, 16'h0020, 16'd0, 8'h09, R_ACK, 2'b00);
    chk("run_duty_kept", 64'(duty_num[7:0]), 64'd5);

    // pwm_valid ignored when burst count is zero
    @(negedge sys_clk); pwm_valid = 2'b01;
    @(negedge sys_clk); pwm_valid = 2'b00;
    chk("pv_ignored_state", 64'(ch_state[1:0]), 64'd2);
    chk("pv_ignored_done", 64'(ch_done), 64'd0);

    // Error and ignore cases
    cmd("start_busy", 4'h3, 4'd0, 16'h0, 16'd0, 8'h0, R_ERR, 2'b00);
    chk("start_busy_state", 64'(ch_state[1:0]), 64'd2);
    cmd("cfg_bad_ch", 4'h1, 4'd2, 16'h1234, 16'd0, 8'h77, R_ERR, 2'b00);
    cmd("stop_bad_ch", 4'h4, 4'd2, 16'h0, 16'd0, 8'h0, R_ERR, 2'b00);
    cmd("op8", 4'h8, 4'd0, 16'h0, 16'd0, 8'h0, R_NONE, 2'b00);
    chk("op8_state", 64'(ch_state), 64'h2);

    // STOP in RUN with busy held: DRAIN for 5 cycles, then IDLE
    pwm_busy = 2'b01;
    cmd("stop_run", 4'h4, 4'd0, 16'h0, 16'd0, 8'h0, R_ACK, 2'b00);
    chk("drain_1", 64'(ch_state[1:0]), 64'd3);
    chk("drain_en", 64'(pwm_en[0]), 64'd0);
    for (int k = 2; k <= 5; k++) begin
      @(negedge sys_clk);
      chk($sformatf("drain_%0d", k), 64'(ch_state[1:0]), 64'd3);
    end
    pwm_busy = 2'b00;
    @(negedge sys_clk);
    chk("drain_exit", 64'(ch_state[1:0]), 64'd0);

    // CFG_B with burst count, START, end-of-burst
    cmd("cfgb0", 4'h2, 4'd0, 16'hA5A5, 16'd0, 8'd4, R_ACK, 2'b00);
    cmd("start0b", 4'h3, 4'd0, 16'h0, 16'd0, 8'h0, R_ACK, 2'b00);
    chk("load_duty", 64'(duty_num[7:0]), 64'd9);
    chk("load_des", 64'(pulse_dessert[15:0]), 64'h0020);
    chk("load_pnum", 64'(pulse_num[7:0]), 64'd4);
    chk("load_pat", 64'(pat[15:0]), 64'hA5A5);
    @(negedge sys_clk); pwm_valid = 2'b01;
    @(negedge sys_clk); pwm_valid = 2'b00;
    chk("burst_done", 64'(ch_done), 64'd1);
    chk("burst_en", 64'(pwm_en[0]), 64'd0);
    chk("burst_state", 64'(ch_state[1:0]), 64'd0);
    @(negedge sys_clk);
    chk("burst_done_pulse", 64'(ch_done), 64'd0);

    // STOP coincident with pwm_valid: DRAIN, no ch_done
    cmd("start0c", 4'h3, 4'd0, 16'h0, 16'd0, 8'h0, R_ACK, 2'b00);
    pwm_busy = 2'b01;
    cmd("stop_pv", 4'h4, 4'd0, 16'h0, 16'd0, 8'h0, R_ACK, 2'b01);
    chk("stop_pv_state", 64'(ch_state[1:0]), 64'd3);
    chk("stop_pv_done", 64'(ch_done), 64'd0);
    pwm_busy = 2'b00;
    @(negedge sys_clk);
    chk("stop_pv_idle", 64'(ch_state[1:0]), 64'd0);

    // STOP in IDLE: acked, no effect
    cmd("stop_idle", 4'h4, 4'd0, 16'h0, 16'd0, 8'h0, R_ACK, 2'b00);
    chk("stop_idle_state", 64'(ch_state), 64'd0);

    // START ch1 with delay 3: exactly 3 ARM cycles
    cmd("start1", 4'h3, 4'd1, 16'h0, 16'd3, 8'h0, R_ACK, 2'b00);
    chk("arm_1", 64'(ch_state[3:2]), 64'd1);
    chk("arm_en", 64'(pwm_en[1]), 64'd0);
    @(negedge sys_clk);
    chk("arm_2", 64'(ch_state[3:2]), 64'd1);
    @(negedge sys_clk);
    chk("arm_3", 64'(ch_state[3:2]), 64'd1);
    @(negedge sys_clk);
    chk("arm_run", 64'(ch_state[3:2]), 64'd2);
    chk("arm_run_en", 64'(pwm_en[1]), 64'd1);

    // Reset during ARM with recv_done held high
    cmd("start0d", 4'h3, 4'd0, 16'h0, 16'd5, 8'h0, R_ACK, 2'b00);
    chk("pre_rst_arm", 64'(ch_state[1:0]), 64'd1);
    @(negedge sys_clk);
    dataA = {4'h3, 4'd0}; dataC = 16'd0;
    recv_done = 1'b1;
    sys_rst_n = 1'b0;
    #1;
    chk("arst_state", 64'(ch_state), 64'h0);
    chk("arst_en", 64'(pwm_en), 64'h0);
    chk("arst_duty", 64'(duty_num), 64'h0101);
    chk("arst_pnum", 64'(pulse_num), 64'h0);
    chk("arst_pat", 64'(pat), 64'h0001_0001);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(R_NONE);
      @(negedge sys_clk);
      check_resp($sformatf("held_%0d", k));
      chk($sformatf("held_state_%0d", k), 64'(ch_state), 64'h0);
    end
    recv_done = 1'b0;
    cmd("start_after_rst", 4'h3, 4'd0, 16'h0, 16'd0, 8'h0, R_ACK, 2'b00);
    chk("after_rst_state", 64'(ch_state[1:0]), 64'd2);

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule
`default_nettype wire
